// File: rtl/cordic_sqrt_pkg.sv
// rtl/cordic_sqrt_pkg.sv - shared types and constants for the CORDIC square-root block
package cordic_sqrt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_ITER = 2'd2,
        S_COMP = 2'd3
    } state_t;

    localparam int ITER_PASSES_DEF = 16;
    localparam int IW_DEF          = 20;
    localparam int DW              = 16;
    localparam int FRAC_BITS       = 16;
    localparam int CNT_W           = 5;

    // 1/0.82816 in Q2.14
    localparam logic [DW-1:0] KINV_Q14 = 16'd19784;
    // 0.25 with FRAC_BITS fractional bits
    localparam int QUARTER_Q16 = 16384;

endpackage

// File: rtl/cordic_shift_sched.sv
// rtl/cordic_shift_sched.sv - hyperbolic CORDIC shift schedule ROM (repeats at 4 and 13)
module cordic_shift_sched (
    input  logic [3:0] pass_idx,
    output logic [3:0] shift
);

    always_comb begin
        shift = 4'd1;
        case (pass_idx)
            4'd0:  shift = 4'd1;
            4'd1:  shift = 4'd2;
            4'd2:  shift = 4'd3;
            4'd3:  shift = 4'd4;
            4'd4:  shift = 4'd4;
            4'd5:  shift = 4'd5;
            4'd6:  shift = 4'd6;
            4'd7:  shift = 4'd7;
            4'd8:  shift = 4'd8;
            4'd9:  shift = 4'd9;
            4'd10: shift = 4'd10;
            4'd11: shift = 4'd11;
            4'd12: shift = 4'd12;
            4'd13: shift = 4'd13;
            4'd14: shift = 4'd13;
            4'd15: shift = 4'd14;
            default: shift = 4'd1;
        endcase
    end

endmodule

// File: rtl/cordic_sqrt_seq.sv
// rtl/cordic_sqrt_seq.sv - sequential hyperbolic CORDIC square root, Q2.14 in/out
// Optional gain compensation multiplier enabled by macro CORDIC_GAIN_COMP_EN.
module cordic_sqrt_seq
    import cordic_sqrt_pkg::*;
#(
    parameter int ITER_PASSES = ITER_PASSES_DEF,
    parameter int IW          = IW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   din,
    output logic          busy,
    output logic          done,
    output logic [15:0]   dout
);

    localparam logic signed [IW-1:0]  QUARTER   = IW'(QUARTER_Q16);
    localparam logic [CNT_W-1:0]      LAST_PASS = CNT_W'(ITER_PASSES - 1);
    localparam int                    RW        = IW + 17;

    state_t                 state_q, state_d;
    logic signed [IW-1:0]   x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [15:0]            dout_q, dout_d;
    logic                   done_q, done_d;

    logic [3:0]             shift;
    logic signed [IW-1:0]   din_s, x_sh, y_sh;
    logic signed [RW-1:0]   res_full;
    logic [15:0]            res_sat;

    cordic_shift_sched u_sched (
        .pass_idx (cnt_q[3:0]),
        .shift    (shift)
    );

    // Q2.14 operand widened to 16 fractional bits
    assign din_s = {{(IW-18){1'b0}}, din, 2'b00};
    assign x_sh  = x_q >>> shift;
    assign y_sh  = y_q >>> shift;

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [RW-1:0] prod;
    assign prod     = $signed({{17{x_q[IW-1]}}, x_q}) * $signed({{(IW+1){1'b0}}, KINV_Q14});
    assign res_full = prod >>> 16;
`else
    assign res_full = $signed({{17{x_q[IW-1]}}, x_q}) >>> 2;
`endif

    always_comb begin
        res_sat = res_full[15:0];
        if (res_full[RW-1]) begin
            res_sat = 16'h0000;
        end else if (|res_full[RW-1:16]) begin
            res_sat = 16'hFFFF;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                x_d     = din_s + QUARTER;
                y_d     = din_s - QUARTER;
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                // drive y toward zero; x converges to gain * sqrt(din)
                if (y_q[IW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q + x_sh;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q - x_sh;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_PASS) state_d = S_COMP;
            end
            S_COMP: begin
                dout_d  = res_sat;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_cordic_sqrt_seq.sv
// tb/tb_cordic_sqrt_seq.sv - directed self-checking bench for cordic_sqrt_seq
module tb_cordic_sqrt_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int E_100 = 16384;
    localparam int E_025 = 8192;
    localparam int E_200 = 23170;
    localparam int E_050 = 11585;
`else
    localparam int E_100 = 13569;
    localparam int E_025 = 6784;
    localparam int E_200 = 19189;
    localparam int E_050 = 9594;
`endif

    cordic_sqrt_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        n_checks++;
        if ((obs - exp > tol) || (exp - obs > tol)) begin
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end else begin
            n_pass++;
        end
    endtask

    // caller is at #1 after a rising edge; returns at #1 after the edge that samples start
    task automatic launch(input logic [15:0] v);
        start = 1'b1;
        din   = v;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // counts edges after the start edge until done; optionally pulses start with alt din
    task automatic wait_done(input int p1, input int p2, input logic [15:0] alt,
                             output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = busy ? 1 : 0;
        while (edges < 40) begin
            @(posedge clk);
            #1 edges++;
            start = 1'b0;
            if (done) break;
            if (busy) busy_cnt++;
            if (edges == p1 || edges == p2) begin
                start = 1'b1;
                din   = alt;
            end
        end
    endtask

    task automatic run(input string tag, input logic [15:0] v, input int exp);
        int e, b;
        launch(v);
        wait_done(-1, -1, 16'h0, e, b);
        check({tag, "_dout"}, int'(dout), exp, 4);
        check({tag, "_lat"}, e, 18, 0);
    endtask

    initial begin
        int e, b, nd;
        rst_n = 1'b0;
        start = 1'b0;
        din   = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_busy", int'(busy), 0, 0);
        check("rst_done", int'(done), 0, 0);
        check("rst_dout", int'(dout), 0, 0);

        launch(16'd16384);
        wait_done(-1, -1, 16'h0, e, b);
        check("one_dout", int'(dout), E_100, 4);
        check("one_lat", e, 18, 0);
        check("one_busy_cycles", b, 18, 0);
        check("one_busy_at_done", int'(busy), 0, 0);
        @(posedge clk);
        #1 check("one_done_pulse", int'(done), 0, 0);

        run("quarter", 16'd4096, E_025);
        run("two", 16'd32768, E_200);
        run("half", 16'd8192, E_050);

        // start pulses while busy are ignored, din changes too late to matter
        launch(16'd16384);
        wait_done(3, 10, 16'd4096, e, b);
        check("ign_dout", int'(dout), E_100, 4);
        check("ign_lat", e, 18, 0);
        nd = 1;
        repeat (25) begin
            @(posedge clk);
            #1 if (done) nd++;
        end
        check("ign_single_done", nd, 1, 0);

        // reset one edge during ITER pass 7 (edge 9 after start)
        launch(16'd32768);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("abort_busy", int'(busy), 0, 0);
        check("abort_done", int'(done), 0, 0);
        check("abort_dout", int'(dout), 0, 0);
        nd = 0;
        repeat (25) begin
            @(posedge clk);
            #1 if (done) nd++;
        end
        check("abort_no_done", nd, 0, 0);
        run("post_abort", 16'd4096, E_025);

        // back-to-back: new start in the done cycle
        launch(16'd16384);
        wait_done(-1, -1, 16'h0, e, b);
        check("b2b_first", int'(dout), E_100, 4);
        launch(16'd32768);
        wait_done(-1, -1, 16'h0, e, b);
        check("b2b_gap", e + 1, 19, 0);
        check("b2b_second", int'(dout), E_200, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
